rtc_gen: RTL and testbench

//  Fractional (phase-accumulator) generator for the real-time clock that drives the CLINT rt_clk input.

---
 rtl/rtc_gen_if.sv | 29 ++
 rtl/rtc_gen.sv | 109 ++++++++++
 tb/tb_rtc_gen.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_gen_if.sv
// rtc_gen_if: valid/ready register bus shared by the CLINT and the rtc_gen block.
//   valid    request valid (master -> slave)
//   address  request byte address (master -> slave)
//   wdata    write data (master -> slave)
//   wstrb    write strobe, all ones = write, anything else = read (master -> slave)
//   rdata    registered read data (slave -> master)
//   ready    one-cycle response pulse (slave -> master)
`timescale 1ns/1ps
interface rtc_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                valid;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   rdata;
    logic                ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/rtc_gen.sv
// rtc_gen: phase-accumulator generator for the 32.768 kHz real-time clock that
// feeds the CLINT rt_clk pin. Every system clock the accumulator advances by INC
// and the accumulator MSB becomes rt_clk, so f_rt = f_clk * INC / 2^ACC_W.
// Rising edges of rt_clk are counted in TICKS.
// Ports:
//   clk      system clock, all logic on posedge
//   reset    asynchronous, active-low reset
//   bus      register bus slave (CTRL, INC, ACC, TICKS selected by address[3:2])
//   rt_clk   generated real-time clock, straight from a flop
//   rt_tick  one-cycle pulse coincident with each rt_clk rise
`timescale 1ns/1ps
module rtc_gen #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          ACC_W       = 32,
    parameter logic [31:0] INC_DEFAULT = 32'h0015798F,
    parameter bit          EN_DEFAULT  = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    rtc_gen_if.slave bus,
    output logic     rt_clk,
    output logic     rt_tick
);

    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_INC   = 2'd1,
        REG_ACC   = 2'd2,
        REG_TICKS = 2'd3
    } reg_sel_t;

    logic              enable;
    logic [ACC_W-1:0]  inc;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [31:0]       ticks;
    logic [DATA_W-1:0] rd_val;
    reg_sel_t          sel;
    logic              wr;
    logic              wr_ctrl;
    logic              wr_inc;
    logic              tick_clr;
    logic              acc_run;
    logic              unused_addr;

    // Only address[3:2] selects a register; the rest of the address is ignored.
    assign unused_addr = ^{bus.address[ADDR_W-1:4], bus.address[1:0]};

    // Decode the request. A write of enable=0 stops accumulation in the same
    // cycle, so the accumulator is forced to zero instead of advancing.
    always_comb begin
        sel      = reg_sel_t'(bus.address[3:2]);
        wr       = bus.valid && (bus.wstrb == {(DATA_W/8){1'b1}});
        wr_ctrl  = wr && (sel == REG_CTRL);
        wr_inc   = wr && (sel == REG_INC);
        tick_clr = wr_ctrl && bus.wdata[1];
        acc_run  = enable && !(wr_ctrl && !bus.wdata[0]);
        acc_next = acc_run ? acc + inc : '0;
    end

    // Read mux sees the register values before this cycle's update.
    always_comb begin
        rd_val = '0;
        case (sel)
            REG_CTRL:  rd_val[0]         = enable;
            REG_INC:   rd_val[ACC_W-1:0] = inc;
            REG_ACC:   rd_val[ACC_W-1:0] = acc;
            REG_TICKS: rd_val[31:0]      = ticks;
            default:   rd_val            = '0;
        endcase
    end

    // Registers, accumulator and edge detect. rt_tick is computed from the
    // next rt_clk so it rises in the same cycle as rt_clk; TICKS then counts
    // it one cycle later, with a clear request taking priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable    <= EN_DEFAULT;
            inc       <= INC_DEFAULT[ACC_W-1:0];
            acc       <= '0;
            rt_clk    <= 1'b0;
            rt_tick   <= 1'b0;
            ticks     <= '0;
            bus.rdata <= '0;
            bus.ready <= 1'b0;
        end else begin
            bus.ready <= bus.valid;
            if (bus.valid) begin
                bus.rdata <= rd_val;
            end
            if (wr_ctrl) begin
                enable <= bus.wdata[0];
            end
            if (wr_inc) begin
                inc <= bus.wdata[ACC_W-1:0];
            end
            acc     <= acc_next;
            rt_clk  <= acc_next[ACC_W-1];
            rt_tick <= acc_next[ACC_W-1] & ~rt_clk;
            if (tick_clr) begin
                ticks <= '0;
            end else if (rt_tick) begin
                ticks <= ticks + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_gen.sv
// tb_rtc_gen: self-checking bench for rtc_gen. The reference model uses the
// closed-form behaviour of a phase accumulator started from zero: after k
// accumulations the phase is k*INC, rt_clk is bit 31 of that phase, and the
// number of rt_clk rises so far is floor((k*INC + 2^31) / 2^32).
`timescale 1ns/1ps
module tb_rtc_gen;

    localparam logic [31:0] INC_DEF = 32'h0015798F;
    localparam logic [31:0] A_CTRL  = 32'h0;
    localparam logic [31:0] A_INC   = 32'h4;
    localparam logic [31:0] A_ACC   = 32'h8;
    localparam logic [31:0] A_TICKS = 32'hC;

    logic   clk;
    logic   reset;
    logic   rt_clk;
    logic   rt_tick;
    int     errors;
    int     checks;
    longint cyc;

    rtc_gen_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rtc_gen #(
        .ADDR_W(32), .DATA_W(32), .ACC_W(32),
        .INC_DEFAULT(INC_DEF), .EN_DEFAULT(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .rt_clk(rt_clk),
        .rt_tick(rt_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of posedges seen so far; stable when read at a negedge.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model_rises(input logic [63:0] k, input logic [31:0] inc);
        logic [63:0] phase;
        phase = k * {32'b0, inc};
        return (phase + 64'h8000_0000) >> 32;
    endfunction

    function automatic logic model_clk(input logic [63:0] k, input logic [31:0] inc);
        logic [63:0] phase;
        phase = k * {32'b0, inc};
        return phase[31];
    endfunction

    function automatic logic model_tick(input logic [63:0] k, input logic [31:0] inc);
        return (model_rises(k, inc) - model_rises(k - 1, inc)) == 64'd1;
    endfunction

    function automatic logic [31:0] model_acc(input logic [63:0] k, input logic [31:0] inc);
        logic [63:0] phase;
        phase = k * {32'b0, inc};
        return phase[31:0];
    endfunction

    // One bus request: driven at a negedge, sampled at the next posedge, the
    // response collected at the following negedge. s is the sampling posedge index.
    task automatic bus_req(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [31:0] rd, output logic rdy, output longint s);
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.address = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        s = cyc + 1;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
        rd  = bus.rdata;
        rdy = bus.ready;
    endtask

    // Clear TICKS with accumulation stopped, load INC, then enable. base is the
    // index of the enabling posedge; accumulation k happens at posedge base+k.
    task automatic enable_at(input logic [31:0] inc, output longint base);
        logic [31:0] rd;
        logic        rdy;
        longint      s;
        bus_req(A_CTRL, 32'h2, 4'hF, rd, rdy, s);
        bus_req(A_INC, inc, 4'hF, rd, rdy, s);
        bus_req(A_CTRL, 32'h1, 4'hF, rd, rdy, s);
        base = s;
    endtask

    // Run at a fixed rate for w clocks checking rt_clk/rt_tick every cycle,
    // then read back TICKS and ACC. sp_lo/sp_hi (non-zero) bound the tick spacing.
    task automatic run_rate(input string name, input logic [31:0] inc, input int w,
                            input int sp_lo, input int sp_hi);
        longint      base;
        longint      k;
        longint      last_k;
        longint      s;
        logic [31:0] rd;
        logic [31:0] exp32;
        logic        rdy;
        enable_at(inc, base);
        last_k = -1;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            k = cyc - base;
            checks++;
            if (rt_clk !== model_clk(k, inc)) begin
                errors++;
                $display("[TB] FAIL %s rt_clk k=%0d: got %b expected %b", name, k, rt_clk, model_clk(k, inc));
            end
            checks++;
            if (rt_tick !== model_tick(k, inc)) begin
                errors++;
                $display("[TB] FAIL %s rt_tick k=%0d: got %b expected %b", name, k, rt_tick, model_tick(k, inc));
            end
            if (rt_tick === 1'b1) begin
                if (sp_lo != 0 && last_k >= 0) begin
                    checks++;
                    if ((k - last_k) < sp_lo || (k - last_k) > sp_hi) begin
                        errors++;
                        $display("[TB] FAIL %s tick_spacing: got %0d expected %0d..%0d", name, k - last_k, sp_lo, sp_hi);
                    end
                end
                last_k = k;
            end
        end
        bus_req(A_TICKS, 32'h0, 4'h0, rd, rdy, s);
        exp32 = 32'(model_rises(64'(s - base - 2), inc));
        checks++;
        if (rd !== exp32 || rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ticks_read: got %0d rdy=%b expected %0d rdy=1", name, rd, rdy, exp32);
        end
        bus_req(A_ACC, 32'h0, 4'h0, rd, rdy, s);
        exp32 = model_acc(64'(s - base - 1), inc);
        checks++;
        if (rd !== exp32) begin
            errors++;
            $display("[TB] FAIL %s acc_read: got %h expected %h", name, rd, exp32);
        end
    endtask

    task automatic test_reset();
        longint      base;
        longint      s;
        logic [31:0] rd;
        logic        rdy;
        reset = 1'b0;
        #23;
        @(negedge clk);
        reset = 1'b1;
        base = cyc;
        @(negedge clk);
        checks++;
        if (rt_clk !== 1'b0 || bus.ready !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got rt_clk=%b ready=%b rdata=%h expected 0 0 0", rt_clk, bus.ready, bus.rdata);
        end
        bus_req(A_INC, 32'h0, 4'h0, rd, rdy, s);
        checks++;
        if (rd !== INC_DEF || rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_inc: got %h rdy=%b expected %h rdy=1", rd, rdy, INC_DEF);
        end
        bus_req(A_CTRL, 32'h0, 4'h0, rd, rdy, s);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %h expected 00000001", rd);
        end
        bus_req(A_ACC, 32'h0, 4'h0, rd, rdy, s);
        checks++;
        if (rd !== model_acc(64'(s - base - 1), INC_DEF)) begin
            errors++;
            $display("[TB] FAIL reset_acc: got %h expected %h", rd, model_acc(64'(s - base - 1), INC_DEF));
        end
    endtask

    task automatic test_default_rate();
        run_rate("default_rate", INC_DEF, 30518, 3051, 3052);
    endtask

    task automatic test_rates();
        run_rate("inc_zero", 32'h0000_0000, 20, 0, 0);
        run_rate("inc_quarter", 32'h4000_0000, 16, 4, 4);
        run_rate("inc_half", 32'h8000_0000, 16, 2, 2);
    endtask

    task automatic test_disable();
        localparam logic [31:0] INC = 32'h0100_0000;
        longint      base;
        longint      s;
        logic [31:0] rd;
        logic        rdy;
        bit          found;
        enable_at(INC, base);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (rt_clk === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL disable_wait_high: got timeout expected rt_clk=1 within 400 clk");
        end
        bus_req(A_CTRL, 32'h0, 4'hF, rd, rdy, s);
        checks++;
        if (rt_clk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disable_rt_clk: got %b expected 0", rt_clk);
        end
        bus_req(A_ACC, 32'h0, 4'h0, rd, rdy, s);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL disable_acc: got %h expected 0", rd);
        end
        bus_req(A_TICKS, 32'h0, 4'h0, rd, rdy, s);
        checks++;
        if (rd !== 32'd1) begin
            errors++;
            $display("[TB] FAIL disable_ticks: got %0d expected 1", rd);
        end
        repeat (100) @(negedge clk);
        bus_req(A_TICKS, 32'h0, 4'h0, rd, rdy, s);
        checks++;
        if (rd !== 32'd1 || rt_clk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disable_hold: got ticks=%0d rt_clk=%b expected 1 0", rd, rt_clk);
        end
        bus_req(A_CTRL, 32'h1, 4'hF, rd, rdy, s);
        base = s;
        repeat (300) @(negedge clk);
        bus_req(A_TICKS, 32'h0, 4'h0, rd, rdy, s);
        checks++;
        if (rd !== 32'(1 + model_rises(64'(s - base - 2), INC))) begin
            errors++;
            $display("[TB] FAIL resume_ticks: got %0d expected %0d", rd, 32'(1 + model_rises(64'(s - base - 2), INC)));
        end
    endtask

    task automatic test_back_to_back();
        localparam logic [31:0] INC = 32'h8000_0000;
        longint      base;
        longint      x;
        longint      r;
        logic [31:0] exp_t;
        bit          found;
        enable_at(INC, base);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (rt_tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL clr_wait_tick: got timeout expected rt_tick within 10 clk");
        end
        // Write CTRL=3 sampled at the posedge where the pending tick is counted.
        bus.valid   = 1'b1;
        bus.address = A_CTRL;
        bus.wdata   = 32'h3;
        bus.wstrb   = 4'hF;
        x = cyc + 1 - base;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_write_ready: got %b expected 1", bus.ready);
        end
        // Three reads on consecutive clocks.
        bus.address = A_TICKS;
        bus.wstrb   = 4'h0;
        bus.wdata   = 32'h0;
        r = cyc + 1 - base;
        exp_t = 32'(model_rises(64'(r - 2), INC) - model_rises(64'(x - 1), INC));
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.rdata !== exp_t) begin
            errors++;
            $display("[TB] FAIL b2b_ticks: got rdy=%b %0d expected rdy=1 %0d", bus.ready, bus.rdata, exp_t);
        end
        bus.address = A_CTRL;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.rdata !== 32'h1) begin
            errors++;
            $display("[TB] FAIL b2b_ctrl: got rdy=%b %h expected rdy=1 00000001", bus.ready, bus.rdata);
        end
        bus.address = A_INC;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.rdata !== INC) begin
            errors++;
            $display("[TB] FAIL b2b_inc: got rdy=%b %h expected rdy=1 %h", bus.ready, bus.rdata, INC);
        end
        bus.valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_drop: got %b expected 0", bus.ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] inc;
        logic [31:0] junk;
        logic [31:0] rd;
        logic [3:0]  strb;
        logic        rdy;
        longint      s;
        int          w;
        for (int n = 0; n < 4; n++) begin
            inc = $urandom_range(32'h8000_0000, 32'h0010_0000);
            w   = $urandom_range(400, 50);
            run_rate($sformatf("random%0d", n), inc, w, 0, 0);
            // A partial strobe is a read, so INC must not change.
            junk = $urandom;
            strb = 4'($urandom_range(14, 1));
            bus_req(A_INC, junk, strb, rd, rdy, s);
            bus_req(A_INC, 32'h0, 4'h0, rd, rdy, s);
            checks++;
            if (rd !== inc) begin
                errors++;
                $display("[TB] FAIL random%0d partial_strobe: got %h expected %h", n, rd, inc);
            end
            bus_req(A_INC, junk, 4'hF, rd, rdy, s);
            bus_req(A_INC, 32'h0, 4'h0, rd, rdy, s);
            checks++;
            if (rd !== junk) begin
                errors++;
                $display("[TB] FAIL random%0d inc_readback: got %h expected %h", n, rd, junk);
            end
        end
    endtask

    task automatic test_async_reset();
        longint base;
        enable_at(32'h8000_0000, base);
        checks++;
        if (rt_clk !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arst_pre_clk: got %b expected 0", rt_clk);
        end
        bus.valid   = 1'b1;
        bus.address = A_CTRL;
        bus.wstrb   = 4'h0;
        @(posedge clk);
        #2;
        checks++;
        if (bus.ready !== 1'b1 || rt_clk !== 1'b1 || rt_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arst_pre_state: got ready=%b rt_clk=%b rt_tick=%b expected 1 1 1", bus.ready, rt_clk, rt_tick);
        end
        reset = 1'b0;
        bus.valid = 1'b0;
        #0.5;
        checks++;
        if (bus.ready !== 1'b0 || rt_clk !== 1'b0 || rt_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arst_drop: got ready=%b rt_clk=%b rt_tick=%b expected 0 0 0", bus.ready, rt_clk, rt_tick);
        end
        #0.5;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL arst_no_ready cycle %0d: got %b expected 0", i, bus.ready);
            end
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b0;
        bus.valid   = 1'b0;
        bus.address = '0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        test_reset();
        test_default_rate();
        test_rates();
        test_disable();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
